// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//   IF-stage PC sequencer placed directly after the branch target buffer.
//   Owns the fetch PC and picks the next one with the priority
//   EX redirect > BTB prediction > PC+4. Keeps at most one instruction-memory
//   request outstanding and hands {pc, instr, prediction} to IF/ID.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   imem_req_*          fetch request (valid/ready), address = current pc
//   imem_resp_*         one-cycle response strobe + instruction word
//   btb_lookup_*        BTB lookup strobe/pc; btb_hit/btb_target same cycle
//   redirect_*          EX redirect (highest priority, any state)
//   if_id_*             fetched instruction + prediction to IF/ID (valid/ready)
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = 32'h0000_0000
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req_valid,
    input  logic                 imem_req_ready,
    output logic [XLEN-1:0]      imem_req_addr,
    input  logic                 imem_resp_valid,
    input  logic [31:0]          imem_resp_data,
    output logic                 btb_lookup_enable,
    output logic [XLEN-1:0]      btb_lookup_pc,
    input  logic                 btb_hit,
    input  logic [XLEN-1:0]      btb_target,
    input  logic                 redirect_valid,
    input  logic [XLEN-1:0]      redirect_pc,
    output logic                 if_id_valid,
    input  logic                 if_id_ready,
    output logic [XLEN-1:0]      if_id_pc,
    output logic [31:0]          if_id_instr,
    output logic                 if_id_pred_taken,
    output logic [XLEN-1:0]      if_id_pred_target
);

    typedef enum logic [1:0] {
        ST_REQ   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_HOLD  = 2'b10,
        ST_DRAIN = 2'b11
    } state_t;

    state_t            state_r;
    state_t            state_next_s;

    logic [XLEN-1:0]   pc_r;
    logic [XLEN-1:0]   req_pc_r;
    logic              req_taken_r;
    logic [XLEN-1:0]   req_target_r;

    logic              if_id_valid_r;
    logic [XLEN-1:0]   if_id_pc_r;
    logic [31:0]       if_id_instr_r;
    logic              if_id_pred_taken_r;
    logic [XLEN-1:0]   if_id_pred_target_r;

    logic [XLEN-1:0]   pc_plus4_s;
    logic [XLEN-1:0]   pred_target_s;
    logic [XLEN-1:0]   redirect_aligned_s;
    logic              req_fire_s;
    logic              resp_capture_s;

    // Next sequential PC wraps modulo 2^XLEN; BTB target is taken as-is.
    assign pc_plus4_s         = pc_r + {{(XLEN-3){1'b0}}, 3'd4};
    assign pred_target_s      = btb_hit ? btb_target : pc_plus4_s;
    // Redirect targets are forced word-aligned by masking the two low bits.
    assign redirect_aligned_s = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};

    // Request is only accepted in REQ and never in a redirect cycle.
    assign req_fire_s     = imem_req_valid & imem_req_ready;
    // A response is kept only when it is not killed by a same-cycle redirect.
    assign resp_capture_s = (state_r == ST_WAIT) & imem_resp_valid & ~redirect_valid;

    // Address outputs come straight from the pc register (no path from redirect).
    assign imem_req_addr     = pc_r;
    assign btb_lookup_pc     = pc_r;
    assign if_id_valid       = if_id_valid_r;
    assign if_id_pc          = if_id_pc_r;
    assign if_id_instr       = if_id_instr_r;
    assign if_id_pred_taken  = if_id_pred_taken_r;
    assign if_id_pred_target = if_id_pred_target_r;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_REQ;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; redirect overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_REQ: begin
                if (req_fire_s) begin
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_next_s = imem_resp_valid ? ST_REQ : ST_DRAIN;
                end else if (imem_resp_valid) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_HOLD: begin
                // if_id_valid is always 1 here, so ready alone completes the handshake.
                if (redirect_valid || if_id_ready) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            ST_DRAIN: begin
                if (imem_resp_valid) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: begin
                state_next_s = ST_REQ;
            end
        endcase
    end

    // FSM outputs: request/lookup strobes; request is gated combinationally by redirect.
    always_comb begin
        imem_req_valid    = 1'b0;
        btb_lookup_enable = 1'b0;
        case (state_r)
            ST_REQ: begin
                btb_lookup_enable = 1'b1;
                if (redirect_valid) begin
                    imem_req_valid = 1'b0;
                end else begin
                    imem_req_valid = 1'b1;
                end
            end
            default: begin
                imem_req_valid    = 1'b0;
                btb_lookup_enable = 1'b0;
            end
        endcase
    end

    // Fetch PC and the prediction captured with the in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r         <= RESET_PC;
            req_pc_r     <= {XLEN{1'b0}};
            req_taken_r  <= 1'b0;
            req_target_r <= {XLEN{1'b0}};
        end else if (redirect_valid) begin
            pc_r <= redirect_aligned_s;
        end else if (req_fire_s) begin
            pc_r         <= pred_target_s;
            req_pc_r     <= pc_r;
            req_taken_r  <= btb_hit;
            req_target_r <= pred_target_s;
        end
    end

    // IF/ID output register: filled from a kept response, cleared on handshake or redirect.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_valid_r       <= 1'b0;
            if_id_pc_r          <= {XLEN{1'b0}};
            if_id_instr_r       <= 32'h0000_0000;
            if_id_pred_taken_r  <= 1'b0;
            if_id_pred_target_r <= {XLEN{1'b0}};
        end else begin
            if (redirect_valid) begin
                if_id_valid_r <= 1'b0;
            end else if (resp_capture_s) begin
                if_id_valid_r <= 1'b1;
            end else if ((state_r == ST_HOLD) && if_id_ready) begin
                if_id_valid_r <= 1'b0;
            end
            if (resp_capture_s) begin
                if_id_pc_r          <= req_pc_r;
                if_id_instr_r       <= imem_resp_data;
                if_id_pred_taken_r  <= req_taken_r;
                if_id_pred_target_r <= req_target_r;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        btb_lookup_enable;
    logic [31:0] btb_lookup_pc;
    logic        btb_hit;
    logic [31:0] btb_target;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_valid;
    logic        if_id_ready;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_pred_taken;
    logic [31:0] if_id_pred_target;

    fetch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .imem_req_valid    (imem_req_valid),
        .imem_req_ready    (imem_req_ready),
        .imem_req_addr     (imem_req_addr),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .btb_lookup_enable (btb_lookup_enable),
        .btb_lookup_pc     (btb_lookup_pc),
        .btb_hit           (btb_hit),
        .btb_target        (btb_target),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .if_id_valid       (if_id_valid),
        .if_id_ready       (if_id_ready),
        .if_id_pc          (if_id_pc),
        .if_id_instr       (if_id_instr),
        .if_id_pred_taken  (if_id_pred_taken),
        .if_id_pred_target (if_id_pred_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        redir;
        logic [31:0] redir_pc;
        logic        hit;
        logic [31:0] tgt;
        int          lat;
        int          stall;
        logic [31:0] exp_addr;
        logic        exp_taken;
        logic [31:0] exp_tgt;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] tgt;
    } exp_t;

    vec_t vecs[9];
    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h13A5_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare every completed IF/ID handshake against the queue head.
    always @(negedge clk) begin
        if (!reset && if_id_valid && if_id_ready && !redirect_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got pc %h expected none", if_id_pc);
            end else begin
                mon_e = sb_q.pop_front();
                check("ifid_pc", if_id_pc, mon_e.pc);
                check("ifid_instr", if_id_instr, mon_e.instr);
                check("ifid_taken", {31'd0, if_id_pred_taken}, {31'd0, mon_e.taken});
                check("ifid_target", if_id_pred_target, mon_e.tgt);
            end
        end
    end

    task automatic run_vec(input vec_t v);
        exp_t e;
        if (v.redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = v.redir_pc;
            imem_req_ready = 1'b1;
            #1;
            check("req_gated_by_redirect", {31'd0, imem_req_valid}, 32'd0);
            step();
            redirect_valid = 1'b0;
            imem_req_ready = 1'b0;
        end
        #1;
        check("req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("req_addr", imem_req_addr, v.exp_addr);
        check("btb_lookup_en", {31'd0, btb_lookup_enable}, 32'd1);
        check("btb_lookup_pc", btb_lookup_pc, v.exp_addr);
        btb_hit        = v.hit;
        btb_target     = v.tgt;
        imem_req_ready = 1'b1;
        e = '{v.exp_addr, instr_of(v.exp_addr), v.exp_taken, v.exp_tgt};
        sb_q.push_back(e);
        step();
        btb_hit        = 1'b0;
        btb_target     = 32'h0000_0000;
        imem_req_ready = 1'b0;
        for (int i = 1; i < v.lat; i++) begin
            check("wait_no_valid", {31'd0, if_id_valid}, 32'd0);
            check("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
            step();
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(v.exp_addr);
        step();
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        check("latency_valid", {31'd0, if_id_valid}, 32'd1);
        for (int i = 0; i < v.stall; i++) begin
            check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
            check("hold_valid", {31'd0, if_id_valid}, 32'd1);
            check("hold_pc", if_id_pc, v.exp_addr);
            check("hold_instr", if_id_instr, instr_of(v.exp_addr));
            step();
        end
        if_id_ready = 1'b1;
        step();
        if_id_ready = 1'b0;
        check("valid_cleared", {31'd0, if_id_valid}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        redir  redir_pc       hit   tgt            lat stall exp_addr       taken exp_tgt
        vecs[0] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 0, 32'h0000_0000, 1'b0, 32'h0000_0004};
        vecs[1] = '{1'b0, 32'h0,         1'b0, 32'h0,         2, 0, 32'h0000_0004, 1'b0, 32'h0000_0008};
        vecs[2] = '{1'b0, 32'h0,         1'b1, 32'h0000_0040, 1, 0, 32'h0000_0008, 1'b1, 32'h0000_0040};
        vecs[3] = '{1'b0, 32'h0,         1'b0, 32'h0,         3, 0, 32'h0000_0040, 1'b0, 32'h0000_0044};
        vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h1000_0002, 1, 0, 32'h0000_0044, 1'b1, 32'h1000_0002};
        vecs[5] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 0, 32'h1000_0002, 1'b0, 32'h1000_0006};
        vecs[6] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 5, 32'h1000_0006, 1'b0, 32'h1000_000A};
        vecs[7] = '{1'b1, 32'hFFFF_FFFD, 1'b0, 32'h0,         1, 0, 32'hFFFF_FFFC, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b0, 32'h0,         1'b0, 32'h0,         1, 0, 32'h0000_0000, 1'b0, 32'h0000_0004};

        reset           = 1'b1;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0000_0000;
        btb_hit         = 1'b0;
        btb_target      = 32'h0000_0000;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0000_0000;
        if_id_ready     = 1'b0;
        #1;
        check("rst_req_addr", imem_req_addr, 32'h0000_0000);
        check("rst_ifid_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_ifid_pc", if_id_pc, 32'h0000_0000);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // In-order fetch, BTB hit, wrap-around via redirect, long IF/ID stall.
        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Redirect while WAIT; response two cycles later is dropped.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();
        redirect_valid = 1'b0;
        #1;
        check("drain_no_req", {31'd0, imem_req_valid}, 32'd0);
        check("drain_no_valid", {31'd0, if_id_valid}, 32'd0);
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hDEAD_BEEF;
        step();
        imem_resp_valid = 1'b0;
        #1;
        check("drop_no_valid", {31'd0, if_id_valid}, 32'd0);
        check("drop_next_addr", imem_req_addr, 32'h0000_0100);
        check("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
        run_vec('{1'b0, 32'h0, 1'b0, 32'h0, 1, 0, 32'h0000_0100, 1'b0, 32'h0000_0104});

        // Redirect in HOLD with if_id_ready=1 drops the held instruction.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = instr_of(32'h0000_0104);
        step();
        imem_resp_valid = 1'b0;
        check("hold_redir_pre_valid", {31'd0, if_id_valid}, 32'd1);
        if_id_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        if_id_ready    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        check("hold_redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("hold_redir_addr", imem_req_addr, 32'h0000_0200);
        check("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);

        // Redirect and response in the same WAIT cycle: back to REQ directly.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h0000_0300;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hCAFE_F00D;
        step();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        check("same_cyc_valid", {31'd0, if_id_valid}, 32'd0);
        check("same_cyc_addr", imem_req_addr, 32'h0000_0300);
        check("same_cyc_req", {31'd0, imem_req_valid}, 32'd1);

        // Asynchronous reset while WAIT; stale response afterwards is ignored.
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_ifid_valid", {31'd0, if_id_valid}, 32'd0);
        check("arst_ifid_pc", if_id_pc, 32'h0000_0000);
        check("arst_ifid_instr", if_id_instr, 32'h0000_0000);
        check("arst_ifid_taken", {31'd0, if_id_pred_taken}, 32'd0);
        check("arst_ifid_target", if_id_pred_target, 32'h0000_0000);
        check("arst_req_addr", imem_req_addr, 32'h0000_0000);
        @(negedge clk);
        reset = 1'b0;
        step();
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        step();
        imem_resp_valid = 1'b0;
        #1;
        check("stale_no_valid", {31'd0, if_id_valid}, 32'd0);
        check("stale_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("stale_req_addr", imem_req_addr, 32'h0000_0000);
        run_vec('{1'b0, 32'h0, 1'b0, 32'h0, 1, 0, 32'h0000_0000, 1'b0, 32'h0000_0004});

        step();
        check("scoreboard_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
